// File: rtl/apb_pkg.sv
// -----------------------------------------------------------------------------
// apb_pkg
// Shared definitions for the APB register-file slave:
//   apb_state_e    - bus-side FSM states (APB_IDLE, APB_SETUP, APB_ACCESS)
//   APB_MAX_WAIT   - largest supported number of inserted wait states
//   APB_WAIT_W     - width of the wait-state counter
//   apb_wait_limit - clamps a wait-state parameter into the counter range
// -----------------------------------------------------------------------------
package apb_pkg;

   typedef enum logic [1:0] {
      APB_IDLE   = 2'd0,
      APB_SETUP  = 2'd1,
      APB_ACCESS = 2'd2
   } apb_state_e;

   localparam int APB_MAX_WAIT = 15;
   localparam int APB_WAIT_W   = 4;

   // Out-of-range parameter values saturate instead of silently wrapping.
   function automatic logic [APB_WAIT_W-1:0] apb_wait_limit(input int ws);
      if (ws > APB_MAX_WAIT) begin
         return APB_WAIT_W'(APB_MAX_WAIT);
      end
      if (ws < 0) begin
         return '0;
      end
      return APB_WAIT_W'(ws);
   endfunction

endpackage : apb_pkg

// File: rtl/apb_reg_array.sv
// -----------------------------------------------------------------------------
// apb_reg_array
// Single-port register storage with byte-lane write masking.
// Ports:
//   pclk   in   clock, rising edge
//   rst_n  in   synchronous active-low reset, clears every register
//   we     in   write enable (one committed write per asserted cycle)
//   idx    in   word index shared by read and write
//   wdata  in   write data
//   wstrb  in   byte-lane enables for the write
//   rdata  out  combinational read of register idx (0 if idx is out of range)
// -----------------------------------------------------------------------------
module apb_reg_array #(
   parameter int DATA_WIDTH = 32,
   parameter int NUM_REGS   = 16,
   parameter int IDX_W      = 6
) (
   input  logic                    pclk,
   input  logic                    rst_n,
   input  logic                    we,
   input  logic [IDX_W-1:0]        idx,
   input  logic [DATA_WIDTH-1:0]   wdata,
   input  logic [DATA_WIDTH/8-1:0] wstrb,
   output logic [DATA_WIDTH-1:0]   rdata
);

   localparam int STRB_W = DATA_WIDTH / 8;

   logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
   logic [DATA_WIDTH-1:0] regs_d [NUM_REGS];

   // NOTE: every always_comb output gets a default first so no path leaves
   // it unassigned; an unassigned path would infer a latch.
   always_comb begin
      regs_d = regs_q;
      if (we) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            if (idx == IDX_W'(i)) begin
               for (int b = 0; b < STRB_W; b++) begin
                  if (wstrb[b]) begin
                     regs_d[i][8*b +: 8] = wdata[8*b +: 8];
                  end
               end
            end
         end
      end
   end

   // Compare-based mux keeps the index width independent of NUM_REGS.
   always_comb begin
      rdata = '0;
      for (int i = 0; i < NUM_REGS; i++) begin
         if (idx == IDX_W'(i)) begin
            rdata = regs_q[i];
         end
      end
   end

   // NOTE: this storage is plain flops, so it is reset like any other state;
   // a RAM macro could not be cleared this way and would need a clear sequence.
   // NOTE: sequential state uses non-blocking assignments only, so every flop
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge pclk) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            regs_q[i] <= '0;
         end
      end else begin
         regs_q <= regs_d;
      end
   end

endmodule : apb_reg_array

// File: rtl/apb_regfile_slave.sv
// -----------------------------------------------------------------------------
// apb_regfile_slave
// APB slave in front of NUM_REGS registers of DATA_WIDTH bits.
// Optional feature macro: APB_PSTRB_EN adds the pstrb port and per-byte writes;
// without it every write updates all byte lanes.
//
// Bus timing seen by this slave: the request is captured in IDLE on the first
// psel & !penable cycle; penable must stay low through the following SETUP
// cycle and then be held high through ACCESS until pready. WAIT_STATES ACCESS
// cycles return pready=0 before the single pready=1 completion cycle.
//
// Ports:
//   pclk     in   clock, rising edge
//   rst_n    in   synchronous active-low reset
//   paddr    in   byte address (ADDR_WIDTH)
//   psel     in   slave select
//   penable  in   access-phase strobe
//   pwrite   in   1 = write, 0 = read
//   pwdata   in   write data (DATA_WIDTH)
//   pstrb    in   byte-lane strobes (only with APB_PSTRB_EN)
//   pready   out  transfer completion, one cycle
//   prdata   out  read data, nonzero only in a good read's pready cycle
//   pslverr  out  error response, qualified by pready
// -----------------------------------------------------------------------------
module apb_regfile_slave
   import apb_pkg::*;
#(
   parameter int ADDR_WIDTH  = 8,
   parameter int DATA_WIDTH  = 32,
   parameter int NUM_REGS    = 16,
   parameter int WAIT_STATES = 0
) (
   input  logic                    pclk,
   input  logic                    rst_n,
   input  logic [ADDR_WIDTH-1:0]   paddr,
   input  logic                    psel,
   input  logic                    penable,
   input  logic                    pwrite,
   input  logic [DATA_WIDTH-1:0]   pwdata,
`ifdef APB_PSTRB_EN
   input  logic [DATA_WIDTH/8-1:0] pstrb,
`endif
   output logic                    pready,
   output logic [DATA_WIDTH-1:0]   prdata,
   output logic                    pslverr
);

   localparam int STRB_W = DATA_WIDTH / 8;
   localparam int LSB    = $clog2(STRB_W);
   localparam int IDX_W  = ADDR_WIDTH - LSB;
   localparam logic [APB_WAIT_W-1:0] WAIT_LAST = apb_wait_limit(WAIT_STATES);

   apb_state_e              state_q, state_d;
   logic [APB_WAIT_W-1:0]   wait_cnt_q, wait_cnt_d;
   logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
   logic                    write_q, write_d;
   logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
`ifdef APB_PSTRB_EN
   logic [STRB_W-1:0]       strb_q, strb_d;
`endif

   logic                    xfer_done;
   logic                    addr_err;
   logic                    reg_we;
   logic [IDX_W-1:0]        reg_idx;
   logic [STRB_W-1:0]       wr_strb;
   logic [DATA_WIDTH-1:0]   reg_rdata;

   // Decode works on the captured address, never the live bus.
   assign reg_idx  = addr_q[ADDR_WIDTH-1:LSB];
   assign addr_err = (addr_q[LSB-1:0] != '0) ||
                     ({1'b0, reg_idx} >= (IDX_W+1)'(NUM_REGS));

`ifdef APB_PSTRB_EN
   assign wr_strb = strb_q;
`else
   assign wr_strb = '1;
`endif

   always_comb begin
      state_d    = state_q;
      wait_cnt_d = wait_cnt_q;
      addr_d     = addr_q;
      write_d    = write_q;
      wdata_d    = wdata_q;
`ifdef APB_PSTRB_EN
      strb_d     = strb_q;
`endif
      xfer_done  = 1'b0;

      case (state_q)
         APB_IDLE: begin
            wait_cnt_d = '0;
            if (psel && !penable) begin
               state_d = APB_SETUP;
               addr_d  = paddr;
               write_d = pwrite;
               wdata_d = pwdata;
`ifdef APB_PSTRB_EN
               strb_d  = pstrb;
`endif
            end
         end
         APB_SETUP: begin
            // An early penable or a dropped select abandons the request.
            if (!psel || penable) begin
               state_d = APB_IDLE;
            end else begin
               state_d = APB_ACCESS;
            end
         end
         APB_ACCESS: begin
            if (!psel || !penable) begin
               state_d    = APB_IDLE;
               wait_cnt_d = '0;
            end else if (wait_cnt_q == WAIT_LAST) begin
               xfer_done  = 1'b1;
               state_d    = APB_IDLE;
               wait_cnt_d = '0;
            end else begin
               wait_cnt_d = wait_cnt_q + 1'b1;
            end
         end
         default: begin
            state_d    = APB_IDLE;
            wait_cnt_d = '0;
         end
      endcase
   end

   // Responses are combinational from the FSM so they are low in IDLE/SETUP
   // and in any ACCESS cycle that is being aborted.
   assign pready  = xfer_done;
   assign pslverr = xfer_done && addr_err;
   assign reg_we  = xfer_done && write_q && !addr_err;
   assign prdata  = (xfer_done && !write_q && !addr_err) ? reg_rdata : '0;

   always_ff @(posedge pclk) begin
      if (!rst_n) begin
         state_q    <= APB_IDLE;
         wait_cnt_q <= '0;
         addr_q     <= '0;
         write_q    <= 1'b0;
         wdata_q    <= '0;
`ifdef APB_PSTRB_EN
         strb_q     <= '0;
`endif
      end else begin
         state_q    <= state_d;
         wait_cnt_q <= wait_cnt_d;
         addr_q     <= addr_d;
         write_q    <= write_d;
         wdata_q    <= wdata_d;
`ifdef APB_PSTRB_EN
         strb_q     <= strb_d;
`endif
      end
   end

   apb_reg_array #(
      .DATA_WIDTH (DATA_WIDTH),
      .NUM_REGS   (NUM_REGS),
      .IDX_W      (IDX_W)
   ) u_reg_array (
      .pclk  (pclk),
      .rst_n (rst_n),
      .we    (reg_we),
      .idx   (reg_idx),
      .wdata (wdata_q),
      .wstrb (wr_strb),
      .rdata (reg_rdata)
   );

endmodule : apb_regfile_slave

// File: tb/tb_apb_regfile_slave.sv
// -----------------------------------------------------------------------------
// tb_apb_regfile_slave
// Two slaves (WAIT_STATES=0 and WAIT_STATES=3) on separate buses sharing clock
// and reset. Stimulus pushes the expected response into a per-slave queue;
// a negedge monitor pops and compares whenever pready is seen.
// -----------------------------------------------------------------------------
module tb_apb_regfile_slave;

   localparam int NREG = 16;

   typedef struct {
      logic [31:0] prdata;
      logic        slverr;
      int          waits;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        psel    [2];
   logic        penable [2];
   logic        pwrite  [2];
   logic [7:0]  paddr   [2];
   logic [31:0] pwdata  [2];
`ifdef APB_PSTRB_EN
   logic [3:0]  pstrb   [2];
`endif
   logic        pready  [2];
   logic        pslverr [2];
   logic [31:0] prdata  [2];

   int          total = 0;
   int          bad   = 0;
   int          acc_cnt [2];
   exp_t        q0 [$];
   exp_t        q1 [$];
   logic [31:0] model [2][NREG];

   always #5 clk = ~clk;

   apb_regfile_slave #(
      .ADDR_WIDTH (8), .DATA_WIDTH (32), .NUM_REGS (NREG), .WAIT_STATES (0)
   ) dut0 (
      .pclk (clk), .rst_n (rst_n), .paddr (paddr[0]), .psel (psel[0]),
      .penable (penable[0]), .pwrite (pwrite[0]), .pwdata (pwdata[0]),
`ifdef APB_PSTRB_EN
      .pstrb (pstrb[0]),
`endif
      .pready (pready[0]), .prdata (prdata[0]), .pslverr (pslverr[0])
   );

   apb_regfile_slave #(
      .ADDR_WIDTH (8), .DATA_WIDTH (32), .NUM_REGS (NREG), .WAIT_STATES (3)
   ) dut1 (
      .pclk (clk), .rst_n (rst_n), .paddr (paddr[1]), .psel (psel[1]),
      .penable (penable[1]), .pwrite (pwrite[1]), .pwdata (pwdata[1]),
`ifdef APB_PSTRB_EN
      .pstrb (pstrb[1]),
`endif
      .pready (pready[1]), .prdata (prdata[1]), .pslverr (pslverr[1])
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_model();
      for (int k = 0; k < 2; k++) begin
         for (int i = 0; i < NREG; i++) begin
            model[k][i] = '0;
         end
      end
   endtask

   task automatic drive_setup(input int k, input logic wr, input logic [7:0] addr,
                              input logic [31:0] data, input logic [3:0] strb);
      psel[k]    = 1'b1;
      penable[k] = 1'b0;
      pwrite[k]  = wr;
      paddr[k]   = addr;
      pwdata[k]  = data;
`ifdef APB_PSTRB_EN
      pstrb[k]   = strb;
`else
      if (strb == 4'h0) pwdata[k] = data; // strobes have no port in this build
`endif
   endtask

   task automatic bus_idle(input int k);
      psel[k]    = 1'b0;
      penable[k] = 1'b0;
   endtask

   // One complete transfer; entered and left at #1 after a rising edge, so
   // consecutive calls produce back-to-back transfers with no idle cycle.
   task automatic apb_xfer(input int k, input logic wr, input logic [7:0] addr,
                           input logic [31:0] data, input logic [3:0] strb);
      exp_t       e;
      int         idx;
      logic       err;
      logic [3:0] eff;
      logic       seen;
      idx = int'(addr >> 2);
      err = (addr[1:0] != 2'b00) || (idx >= NREG);
`ifdef APB_PSTRB_EN
      eff = strb;
`else
      eff = strb | 4'hF;
`endif
      e.waits  = (k == 0) ? 0 : 3;
      e.slverr = err;
      e.prdata = '0;
      if (!err) begin
         if (wr) begin
            for (int b = 0; b < 4; b++) begin
               if (eff[b]) model[k][idx][8*b +: 8] = data[8*b +: 8];
            end
         end else begin
            e.prdata = model[k][idx];
         end
      end
      if (k == 0) q0.push_back(e);
      else        q1.push_back(e);

      drive_setup(k, wr, addr, data, strb);
      step();
      // Request already captured: scramble the bus to prove it is ignored.
      paddr[k]  = 8'($urandom);
      pwdata[k] = $urandom;
      pwrite[k] = ~wr;
      step();
      penable[k] = 1'b1;
      seen = 1'b0;
      for (int n = 0; n < 40 && !seen; n++) begin
         @(negedge clk);
         if (pready[k] === 1'b1) seen = 1'b1;
      end
      check($sformatf("xfer_complete[%0d]", k), 32'(seen), 32'd1);
      step();
      bus_idle(k);
   endtask

   // Scoreboard monitor.
   always @(negedge clk) begin
      exp_t e;
      for (int k = 0; k < 2; k++) begin
         if (rst_n !== 1'b1) begin
            acc_cnt[k] = 0;
         end else if (pready[k] === 1'b1) begin
            if ((k == 0 && q0.size() == 0) || (k == 1 && q1.size() == 0)) begin
               check($sformatf("pready_without_transfer[%0d]", k), 32'(pready[k]), 32'd0);
            end else begin
               if (k == 0) e = q0.pop_front();
               else        e = q1.pop_front();
               check($sformatf("prdata[%0d]", k), prdata[k], e.prdata);
               check($sformatf("pslverr[%0d]", k), 32'(pslverr[k]), 32'(e.slverr));
               check($sformatf("wait_cycles[%0d]", k), 32'(acc_cnt[k]), 32'(e.waits));
            end
            acc_cnt[k] = 0;
         end else begin
            check($sformatf("idle_prdata[%0d]", k), prdata[k], 32'd0);
            check($sformatf("idle_pslverr[%0d]", k), 32'(pslverr[k]), 32'd0);
            if (psel[k] && penable[k]) acc_cnt[k]++;
            else                       acc_cnt[k] = 0;
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
      $fatal(1);
   end

   initial begin
      int          k;
      logic        wr;
      logic [7:0]  a;
      for (int i = 0; i < 2; i++) begin
         psel[i] = 1'b0; penable[i] = 1'b0; pwrite[i] = 1'b0;
         paddr[i] = '0;  pwdata[i] = '0;
`ifdef APB_PSTRB_EN
         pstrb[i] = '0;
`endif
         acc_cnt[i] = 0;
      end
      clear_model();

      // Reset state
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
         check($sformatf("reset_pready[%0d]", i), 32'(pready[i]), 32'd0);
         check($sformatf("reset_pslverr[%0d]", i), 32'(pslverr[i]), 32'd0);
         check($sformatf("reset_prdata[%0d]", i), prdata[i], 32'd0);
      end
      step();
      rst_n = 1'b1;
      apb_xfer(0, 1'b0, 8'h00, 32'h0, 4'hF);
      apb_xfer(1, 1'b0, 8'h3C, 32'h0, 4'hF);

      // Zero wait states: write then read back
      apb_xfer(0, 1'b1, 8'h08, 32'hDEADBEEF, 4'hF);
      apb_xfer(0, 1'b0, 8'h08, 32'h0, 4'hF);

      // Three wait states
      apb_xfer(1, 1'b1, 8'h04, 32'hCAFEF00D, 4'hF);
      apb_xfer(1, 1'b0, 8'h04, 32'h0, 4'hF);

      // Error responses leave storage untouched
      apb_xfer(0, 1'b1, 8'h00, 32'h0BADF00D, 4'hF);
      apb_xfer(0, 1'b1, 8'h40, 32'hFFFFFFFF, 4'hF);
      apb_xfer(0, 1'b0, 8'h02, 32'h0, 4'hF);
      apb_xfer(0, 1'b1, 8'h09, 32'h12121212, 4'hF);
      apb_xfer(0, 1'b0, 8'h00, 32'h0, 4'hF);
      apb_xfer(0, 1'b0, 8'h08, 32'h0, 4'hF);
      apb_xfer(1, 1'b0, 8'hFC, 32'h0, 4'hF);
      apb_xfer(0, 1'b0, 8'h3C, 32'h0, 4'hF);

`ifdef APB_PSTRB_EN
      // Byte-lane strobes, including an all-zero strobe
      apb_xfer(0, 1'b1, 8'h0C, 32'h11223344, 4'hF);
      apb_xfer(0, 1'b1, 8'h0C, 32'hAABBCCDD, 4'b0101);
      apb_xfer(0, 1'b0, 8'h0C, 32'h0, 4'hF);
      apb_xfer(0, 1'b1, 8'h0C, 32'h99999999, 4'h0);
      apb_xfer(0, 1'b0, 8'h0C, 32'h0, 4'hF);
`endif

      // psel dropped mid-ACCESS; the very next cycle starts a new transfer
      apb_xfer(1, 1'b1, 8'h14, 32'hA5A5A5A5, 4'hF);
      drive_setup(1, 1'b1, 8'h14, 32'h5A5A5A5A, 4'hF);
      step();
      step();
      penable[1] = 1'b1;
      step();
      bus_idle(1);
      step();
      apb_xfer(1, 1'b0, 8'h14, 32'h0, 4'hF);

      // penable raised during SETUP abandons the write
      apb_xfer(0, 1'b1, 8'h18, 32'h01020304, 4'hF);
      drive_setup(0, 1'b1, 8'h18, 32'hF0F0F0F0, 4'hF);
      step();
      penable[0] = 1'b1;
      step();
      step();
      bus_idle(0);
      step();
      apb_xfer(0, 1'b0, 8'h18, 32'h0, 4'hF);

      // Reset during ACCESS of a waited write
      apb_xfer(1, 1'b1, 8'h00, 32'h77777777, 4'hF);
      drive_setup(1, 1'b1, 8'h00, 32'h12345678, 4'hF);
      step();
      step();
      penable[1] = 1'b1;
      step();
      rst_n = 1'b0;
      step();
      bus_idle(1);
      @(negedge clk);
      check("pready_in_reset[1]", 32'(pready[1]), 32'd0);
      check("pready_in_reset[0]", 32'(pready[0]), 32'd0);
      step();
      rst_n = 1'b1;
      clear_model();
      apb_xfer(1, 1'b0, 8'h00, 32'h0, 4'hF);

      // Reset in the pready=1 cycle of a zero-wait write
      drive_setup(0, 1'b1, 8'h10, 32'h55AA55AA, 4'hF);
      step();
      step();
      penable[0] = 1'b1;
      rst_n = 1'b0;
      step();
      bus_idle(0);
      step();
      rst_n = 1'b1;
      clear_model();
      apb_xfer(0, 1'b0, 8'h10, 32'h0, 4'hF);
      apb_xfer(0, 1'b0, 8'h08, 32'h0, 4'hF);

      // Randomized traffic, mostly legal addresses, occasional idle gaps
      repeat (160) begin
         k  = int'($urandom_range(0, 1));
         wr = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 3) == 0) a = 8'($urandom);
         else                           a = {2'b00, 4'($urandom), 2'b00};
         apb_xfer(k, wr, a, $urandom, 4'($urandom));
         repeat ($urandom_range(0, 2)) step();
      end

      repeat (5) step();
      check("queue_drained[0]", 32'(q0.size()), 32'd0);
      check("queue_drained[1]", 32'(q1.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule : tb_apb_regfile_slave
